// File: rtl/seqdet_stream_ctrl.sv
// Streams a captured word bit-serially into a sequence detector, with a flush phase first.
// Counts detector hits and records the stream index of the first hit.
module seqdet_stream_ctrl #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 5,
    parameter int FLUSH_CYC = 2,
    parameter int DET_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              msb_first,
    input  logic              abort,
    output logic              det_rst,
    output logic              det_ena,
    output logic              det_bit,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  first_hit_idx
);

    localparam int CYC_MAX = (FLUSH_CYC > DET_LAT) ? FLUSH_CYC : DET_LAT;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              order_msb;
    logic [CNT_W-1:0]  bit_idx;
    logic [CYC_W-1:0]  cyc_cnt;
    logic              hit_vld_p [DET_LAT];
    logic [CNT_W-1:0]  hit_idx_p [DET_LAT];
    logic              job_kill;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic msb);
        return msb ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic msb);
        return msb ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign job_kill = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            order_msb     <= 1'b0;
            bit_idx       <= '0;
            cyc_cnt       <= '0;
            det_rst       <= 1'b0;
            det_ena       <= 1'b0;
            det_bit       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_count     <= '0;
            first_hit_idx <= '1;
        end else begin
            done <= 1'b0;
            // The hit seen on the abort edge still belongs to a bit already sent, so it is kept.
            if (hit_vld_p[DET_LAT-1] && det_hit) begin
                hit_count <= hit_count + 1'b1;
                if (hit_count == '0)
                    first_hit_idx <= hit_idx_p[DET_LAT-1];
            end
            if (job_kill) begin
                state   <= IDLE;
                det_rst <= 1'b0;
                det_ena <= 1'b0;
                det_bit <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            shreg         <= data_in;
                            order_msb     <= msb_first;
                            hit_count     <= '0;
                            first_hit_idx <= '1;
                            cyc_cnt       <= '0;
                            det_rst       <= 1'b1;
                            busy          <= 1'b1;
                            state         <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (cyc_cnt == CYC_W'(FLUSH_CYC - 1)) begin
                            det_rst <= 1'b0;
                            det_ena <= 1'b1;
                            det_bit <= head_bit(shreg, order_msb);
                            shreg   <= shift_word(shreg, order_msb);
                            bit_idx <= '0;
                            state   <= STREAM;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    STREAM: begin
                        if (bit_idx == CNT_W'(DATA_W - 1)) begin
                            det_ena <= 1'b0;
                            det_bit <= 1'b0;
                            cyc_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            det_bit <= head_bit(shreg, order_msb);
                            shreg   <= shift_word(shreg, order_msb);
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (cyc_cnt == CYC_W'(DET_LAT - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Pipe stage 0 tags the bit currently on det_bit; the last stage lines up with det_hit.
    always_ff @(posedge clk) begin
        if (rst || job_kill) begin
            for (int i = 0; i < DET_LAT; i++) begin
                hit_vld_p[i] <= 1'b0;
                hit_idx_p[i] <= '0;
            end
        end else begin
            hit_vld_p[0] <= (state == STREAM);
            hit_idx_p[0] <= bit_idx;
            for (int i = 1; i < DET_LAT; i++) begin
                hit_vld_p[i] <= hit_vld_p[i-1];
                hit_idx_p[i] <= hit_idx_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Bench for seqdet_stream_ctrl with an overlapping "101" Moore detector (one cycle latency).
// Expected results come from scanning the streamed bit sequence directly.
module tb_seqdet_stream_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              msb_first = 1'b0;
    logic              abort = 1'b0;
    logic              det_rst, det_ena, det_bit, det_hit;
    logic              busy, done;
    logic [CNT_W-1:0]  hit_count, first_hit_idx;

    int n_tests = 0;
    int n_fail  = 0;

    seqdet_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLUSH_CYC(2), .DET_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .msb_first(msb_first),
        .abort(abort), .det_rst(det_rst), .det_ena(det_ena), .det_bit(det_bit),
        .det_hit(det_hit), .busy(busy), .done(done), .hit_count(hit_count),
        .first_hit_idx(first_hit_idx)
    );

    always #5 clk = ~clk;

    // Detector: remembers the last three bits accepted; hit when they read 1,0,1.
    logic [2:0] hist;
    always @(posedge clk) begin
        if (rst || det_rst) hist <= 3'b000;
        else if (det_ena)   hist <= {hist[1:0], det_bit};
    end
    assign det_hit = (hist == 3'b101);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hits among the first nbits streamed bits.
    task automatic ref_hits(input logic [DATA_W-1:0] d, input logic m, input int nbits,
                            output int cnt, output int first);
        logic b [DATA_W];
        cnt = 0;
        first = 31;
        for (int k = 0; k < DATA_W; k++) b[k] = m ? d[DATA_W-1-k] : d[k];
        for (int k = 2; k < nbits; k++) begin
            if (b[k-2] && !b[k-1] && b[k]) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done"}, done, 0);
        chk_eq({tag, "_ena"}, det_ena, 0);
        chk_eq({tag, "_drst"}, det_rst, 0);
        chk_eq({tag, "_dbit"}, det_bit, 0);
        chk_eq({tag, "_cnt"}, hit_count, 0);
        chk_eq({tag, "_first"}, first_hit_idx, 5'h1F);
    endtask

    // Launch a job; returns with the start edge just passed and #1 elapsed (cycle T+1).
    task automatic launch(input logic [DATA_W-1:0] d, input logic m);
        @(negedge clk);
        start = 1'b1;
        data_in = d;
        msb_first = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_in = $urandom;
        msb_first = $urandom_range(0, 1);
    endtask

    task automatic run_job(input string tag, input logic [DATA_W-1:0] d, input logic m,
                           input bit repulse);
        int n, cnt, first;
        ref_hits(d, m, DATA_W, cnt, first);
        launch(d, m);
        n = 1;
        chk_eq({tag, "_busy_t1"}, busy, 1);
        while (!done && n < 40) begin
            if (repulse && n == 8) begin
                start = 1'b1;
                data_in = ~d;
                msb_first = ~m;
            end
            if (repulse && n == 9) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq({tag, "_lat"}, n, 20);
        chk_eq({tag, "_busy_done"}, busy, 1);
        chk_eq({tag, "_cnt"}, hit_count, cnt);
        chk_eq({tag, "_first"}, first_hit_idx, first);
        @(posedge clk);
        #1;
        chk_eq({tag, "_done_pulse"}, done, 0);
        chk_eq({tag, "_busy_after"}, busy, 0);
        chk_eq({tag, "_cnt_held"}, hit_count, cnt);
    endtask

    initial begin
        int cnt, first, seen_done;
        logic [DATA_W-1:0] d;
        logic m;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;

        run_job("aaaa_msb", 16'hAAAA, 1'b1, 1'b0);
        run_job("aaaa_lsb", 16'hAAAA, 1'b0, 1'b0);
        run_job("zero", 16'h0000, 1'b1, 1'b0);
        run_job("repulse", 16'hB5AD, 1'b1, 1'b1);
        run_job("ones", 16'hFFFF, 1'b0, 1'b0);

        for (int j = 0; j < 10; j++) begin
            d = $urandom;
            m = $urandom_range(0, 1);
            run_job($sformatf("rnd%0d", j), d, m, $urandom_range(0, 1) == 1);
        end

        // Abort during the 5th streamed bit: hits on bits 0..3 are kept.
        for (int j = 0; j < 3; j++) begin
            d = (j == 0) ? 16'hAAAA : 16'($urandom);
            m = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ref_hits(d, m, 4, cnt, first);
            launch(d, m);
            repeat (6) begin
                @(posedge clk);
                #1;
            end
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk_eq("abort_busy", busy, 0);
            chk_eq("abort_ena", det_ena, 0);
            chk_eq("abort_drst", det_rst, 0);
            chk_eq("abort_cnt", hit_count, cnt);
            chk_eq("abort_first", first_hit_idx, first);
            seen_done = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (done || busy) seen_done++;
            end
            chk_eq("abort_no_done", seen_done, 0);
            chk_eq("abort_cnt_held", hit_count, cnt);
        end

        // start together with abort in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk_eq("idle_abort_busy", busy, 0);
        chk_eq("idle_abort_drst", det_rst, 0);

        // Reset while draining.
        launch(16'hAAAA, 1'b1);
        repeat (18) begin
            @(posedge clk);
            #1;
        end
        chk_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("mid_rst");
        run_job("post_rst", 16'h5A5A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
